fwd_hazard_unit: RTL and testbench
==================================

Name: fwd_hazard_unit

Overview:
- Forwarding and load-use hazard controller for the 5-stage RISC-V pipeline.
- Tracks destination-register state for the instructions in EX, MEM and WB.
- Produces registered sel0/sel1 pairs that steer the two EX-stage operand 4:1 muxes (operand A, operand B).
- Raises a load-use stall that freezes IF/ID and injects a bubble into EX.

Parameters:
- REG_ADDR_W, 5, register address width (x0..x31)
- NUM_REGS, 32, register count; address 0 is hardwired zero

Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  instruction in ID is valid
- id_rs1  in  REG_ADDR_W  ID source register 1
- id_rs2  in  REG_ADDR_W  ID source register 2
- id_uses_rs1  in  1  ID instruction reads rs1
- id_uses_rs2  in  1  ID instruction reads rs2
- id_rd  in  REG_ADDR_W  ID destination register
- id_regwrite  in  1  ID instruction writes rd
- id_memread  in  1  ID instruction is a load
- flush  in  1  branch/jump redirect; kill the ID instruction
- hold  in  1  global pipeline freeze (memory wait)
- fwd_a_sel0  out  1  operand A mux select, bit 0
- fwd_a_sel1  out  1  operand A mux select, bit 1
- fwd_b_sel0  out  1  operand B mux select, bit 0
- fwd_b_sel1  out  1  operand B mux select, bit 1
- stall_load_use  out  1  hold PC and IF/ID; bubble EX (combinational)

Behaviour:
- Clocking and reset: single clock, clk; reset asynchronous active-low, rst_n.
- Select encoding, {sel1, sel0}:
  - 00: ID/EX register-file value
  - 01: MEM/WB writeback result
  - 10: EX/MEM ALU result
  - 11: WB-hold value (optional feature only)
- Internal state: three stage records (ex_, mem_, wb_), each holding rd, regwrite, memread.
- Reset:
  - All stage records cleared (regwrite=0, rd=0).
  - All select outputs 0.
  - stall_load_use=0 while rst_n is low.
- Load-use detection (combinational):
  - stall_load_use = id_valid & ex_memread & ex_regwrite & (ex_rd != 0) & ((id_uses_rs1 & ex_rd==id_rs1) | (id_uses_rs2 & ex_rd==id_rs2)).
  - Forced to 0 when flush or hold is 1.
- Per-operand select, computed from ID inputs and registered (valid during the instruction's EX cycle). Priority order:
  1. ex_regwrite & ex_rd!=0 & ex_rd==rs & !ex_memread -> 10.
  2. mem_regwrite & mem_rd!=0 & mem_rd==rs -> 01.
  3. wb match -> 11 (only when the optional feature is enabled).
  4. Otherwise -> 00.
- Operand with uses_rs=0 -> 00.
- Per-cycle update, first matching rule wins:
  1. hold=1: all state and outputs keep their values.
  2. flush=1: ex_ <- bubble; selects <- 00; mem_ <- ex_; wb_ <- mem_.
  3. stall_load_use=1: ex_ <- bubble; selects <- 00; mem_ and wb_ advance.
  4. Normal:
     - ex_ <- {id_rd, id_regwrite & id_valid, id_memread & id_valid}
     - mem_ <- ex_; wb_ <- mem_
     - selects <- computed values
- Latency:
  - Selects lag the ID inputs by one cycle.
  - A stall lasts exactly one cycle per load-use; after the bubble, the retried instruction forwards 01 from MEM/WB.
- Boundary rules:
  - rd=0 never forwards and never stalls.
  - rs1==rs2 with both used: both operands get the same select.
  - EX and MEM both match rs: EX (10) wins.
  - Reset asserted mid-stall clears stall_load_use immediately (asynchronous).
  - A flush coinciding with a load-use condition produces no stall.

Optional Feature:
- Macro: FWD_WB_HOLD_EN
- Defined:
  - wb_ record participates in matching; a wb_ match (lowest priority) yields select 11.
  - Mux input ind carries the value written back in the previous cycle.
  - Required when the register file is not write-through.
- Undefined:
  - Select 11 is never produced.
  - wb_ record is still kept, but unused by the select logic.
  - Register file must be write-first.

Decomposition:
- Shared package pipe_pkg holds:
  - FWD_RF=2'b00, FWD_WB=2'b01, FWD_EXMEM=2'b10, FWD_WBHOLD=2'b11
  - REG_ADDR_W
  - stage-record typedef {rd, regwrite, memread}
- One sub-module, fwd_sel_calc: the combinational priority encoder for one operand. Instantiate it twice (A and B).

Test Plan:
- Reset: rst_n=0 with random inputs -> all selects 00, stall_load_use=0; after release, first instruction with no hazards -> 00/00.
- EX/MEM forward:
  - Stimulus: add x5 in ID, next cycle sub rs1=x5, rs2=x6.
  - Response: next cycle {a}=10, {b}=00.
  - Repeat with rd=x0 -> a=00.
- Load-use:
  - Stimulus: lw x7, then add rs2=x7.
  - Response: stall_load_use=1 for exactly one cycle, selects 00 (bubble); retried add then gets b=01.
- Priority:
  - Stimulus: add x3, add x3, then or rs1=x3.
  - Response: a=10; with the middle instruction replaced by nop, a=01.
- Hold/flush:
  - hold=1 for 3 cycles mid-hazard -> outputs frozen, stall held off.
  - flush together with a load-use match -> stall=0, next selects 00.
- FWD_WB_HOLD_EN:
  - Stimulus: add x9, two nops, then and rs1=x9.
  - Response: a=11 when defined, 00 when undefined.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: forwarding-mux select codes, register address
// width, the per-stage destination record and a small match helper.
package pipe_pkg;

  localparam int REG_ADDR_W = 5;

  // Operand mux select codes, {sel1, sel0}
  localparam logic [1:0] FWD_RF     = 2'b00;  // ID/EX register-file value
  localparam logic [1:0] FWD_WB     = 2'b01;  // MEM/WB writeback result
  localparam logic [1:0] FWD_EXMEM  = 2'b10;  // EX/MEM ALU result
  localparam logic [1:0] FWD_WBHOLD = 2'b11;  // value written back last cycle

  // Destination-register state carried by the instruction in one stage
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic                  regwrite;
    logic                  memread;
  } stage_rec_t;

  localparam stage_rec_t STAGE_BUBBLE = '{rd: '0, regwrite: 1'b0, memread: 1'b0};

  // A producer matches a source register when it writes a non-zero rd equal to rs
  function automatic logic rd_match(input logic [REG_ADDR_W-1:0] rd,
                                    input logic                  wr,
                                    input logic [REG_ADDR_W-1:0] rs);
    return wr & (rd != '0) & (rd == rs);
  endfunction

endpackage

// File: rtl/fwd_sel_calc.sv
// Forwarding priority encoder for one EX operand.
// Priority: EX/MEM (non-load) > MEM/WB > WB-hold (FWD_WB_HOLD_EN only) > RF.
// Optional feature macro: FWD_WB_HOLD_EN adds the wb stage to the match.
module fwd_sel_calc
  import pipe_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic                  uses_rs,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_fwd_ok,     // ex writes rd and is not a load
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  mem_regwrite,
`ifdef FWD_WB_HOLD_EN
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  wb_regwrite,
`endif
  output logic [1:0]            sel
);

  // Highest-priority matching producer picks the mux input
  always_comb begin
    sel = FWD_RF;
    if (uses_rs) begin
      if (rd_match(ex_rd, ex_fwd_ok, rs)) begin
        sel = FWD_EXMEM;
      end else if (rd_match(mem_rd, mem_regwrite, rs)) begin
        sel = FWD_WB;
      end
`ifdef FWD_WB_HOLD_EN
      else if (rd_match(wb_rd, wb_regwrite, rs)) begin
        sel = FWD_WBHOLD;
      end
`endif
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard controller for the 5-stage pipeline.
// Tracks rd/regwrite/memread for EX, MEM and WB; registers operand A/B mux
// selects for the instruction entering EX; raises a combinational load-use
// stall that holds PC and IF/ID and bubbles EX.
// Optional feature macro: FWD_WB_HOLD_EN (wb stage forwards with select 11).
module fwd_hazard_unit
  import pipe_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int NUM_REGS   = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_regwrite,
  input  logic                  id_memread,
  input  logic                  flush,
  input  logic                  hold,
  output logic                  fwd_a_sel0,
  output logic                  fwd_a_sel1,
  output logic                  fwd_b_sel0,
  output logic                  fwd_b_sel1,
  output logic                  stall_load_use
);

  // The stage record width is fixed by the package; catch mismatched overrides
  if (REG_ADDR_W != pipe_pkg::REG_ADDR_W) begin : g_bad_addr_w
    $error("fwd_hazard_unit: REG_ADDR_W must equal pipe_pkg::REG_ADDR_W");
  end
  if (NUM_REGS != (1 << REG_ADDR_W)) begin : g_bad_num_regs
    $error("fwd_hazard_unit: NUM_REGS must equal 2**REG_ADDR_W");
  end

  stage_rec_t ex_q, mem_q, wb_q;
  stage_rec_t ex_d;
  logic [1:0] a_sel_q, b_sel_q;
  logic [1:0] a_sel_d, b_sel_d;
  logic       rs1_hit_load, rs2_hit_load;
  logic       bubble;

  // Load in EX whose rd is needed by the ID instruction
  always_comb begin
    rs1_hit_load   = id_uses_rs1 & rd_match(ex_q.rd, ex_q.regwrite, id_rs1);
    rs2_hit_load   = id_uses_rs2 & rd_match(ex_q.rd, ex_q.regwrite, id_rs2);
    stall_load_use = rst_n & id_valid & ex_q.memread & ~flush & ~hold &
                     (rs1_hit_load | rs2_hit_load);
  end

  // Flush or load-use inserts a bubble into EX instead of the ID instruction
  always_comb begin
    bubble = flush | stall_load_use;
    ex_d   = '{rd: id_rd, regwrite: id_regwrite & id_valid, memread: id_memread & id_valid};
  end

  fwd_sel_calc u_sel_a (
    .rs           (id_rs1),
    .uses_rs      (id_uses_rs1),
    .ex_rd        (ex_q.rd),
    .ex_fwd_ok    (ex_q.regwrite & ~ex_q.memread),
    .mem_rd       (mem_q.rd),
    .mem_regwrite (mem_q.regwrite),
`ifdef FWD_WB_HOLD_EN
    .wb_rd        (wb_q.rd),
    .wb_regwrite  (wb_q.regwrite),
`endif
    .sel          (a_sel_d)
  );

  fwd_sel_calc u_sel_b (
    .rs           (id_rs2),
    .uses_rs      (id_uses_rs2),
    .ex_rd        (ex_q.rd),
    .ex_fwd_ok    (ex_q.regwrite & ~ex_q.memread),
    .mem_rd       (mem_q.rd),
    .mem_regwrite (mem_q.regwrite),
`ifdef FWD_WB_HOLD_EN
    .wb_rd        (wb_q.rd),
    .wb_regwrite  (wb_q.regwrite),
`endif
    .sel          (b_sel_d)
  );

  // Stage records and registered selects: hold freezes, bubble zeroes EX
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q    <= STAGE_BUBBLE;
      mem_q   <= STAGE_BUBBLE;
      wb_q    <= STAGE_BUBBLE;
      a_sel_q <= FWD_RF;
      b_sel_q <= FWD_RF;
    end else if (!hold) begin
      mem_q <= ex_q;
      wb_q  <= mem_q;
      if (bubble) begin
        ex_q    <= STAGE_BUBBLE;
        a_sel_q <= FWD_RF;
        b_sel_q <= FWD_RF;
      end else begin
        ex_q    <= ex_d;
        a_sel_q <= a_sel_d;
        b_sel_q <= b_sel_d;
      end
    end
  end

  assign fwd_a_sel0 = a_sel_q[0];
  assign fwd_a_sel1 = a_sel_q[1];
  assign fwd_b_sel0 = b_sel_q[0];
  assign fwd_b_sel1 = b_sel_q[1];

  // memread of MEM/WB never matters for forwarding; wb is only read with WB-hold
`ifdef FWD_WB_HOLD_EN
  logic unused_bits;
  assign unused_bits = ^{mem_q.memread, wb_q.memread};
`else
  logic unused_bits;
  assign unused_bits = ^{mem_q.memread, wb_q};
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench for fwd_hazard_unit: directed scenarios with constant
// expectations plus a randomized run checked against an instruction-history
// reference model.
module tb_fwd_hazard_unit;

`ifdef FWD_WB_HOLD_EN
  localparam bit WB_EN = 1'b1;
`else
  localparam bit WB_EN = 1'b0;
`endif

  logic       clk, rst_n;
  logic       id_valid, id_uses_rs1, id_uses_rs2, id_regwrite, id_memread;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       flush, hold;
  logic       fwd_a_sel0, fwd_a_sel1, fwd_b_sel0, fwd_b_sel1, stall_load_use;

  int total = 0;
  int bad   = 0;

  fwd_hazard_unit dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread),
    .flush(flush), .hold(hold),
    .fwd_a_sel0(fwd_a_sel0), .fwd_a_sel1(fwd_a_sel1),
    .fwd_b_sel0(fwd_b_sel0), .fwd_b_sel1(fwd_b_sel1),
    .stall_load_use(stall_load_use)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // hist[0] is the instruction one ahead of ID (in EX), hist[1] two ahead, hist[2] three ahead
  typedef struct {
    int rd;
    bit wr;
    bit ld;
  } ins_t;
  ins_t     hist[3];
  bit [1:0] m_a, m_b;

  function automatic void m_clear();
    for (int i = 0; i < 3; i++) hist[i] = '{rd: 0, wr: 1'b0, ld: 1'b0};
    m_a = 2'b00;
    m_b = 2'b00;
  endfunction

  // Walk older instructions nearest-first; a load one ahead cannot forward yet
  function automatic bit [1:0] m_sel(input int rs, input bit used);
    bit [1:0] code [3];
    code[0] = 2'b10; code[1] = 2'b01; code[2] = 2'b11;
    if (!used) return 2'b00;
    for (int d = 0; d < 3; d++) begin
      if (hist[d].wr && hist[d].rd != 0 && hist[d].rd == rs) begin
        if (d == 0 && hist[d].ld) continue;
        if (d == 2 && !WB_EN) continue;
        return code[d];
      end
    end
    return 2'b00;
  endfunction

  function automatic bit m_stall();
    if (!rst_n || !id_valid || flush || hold) return 1'b0;
    if (!(hist[0].ld && hist[0].wr && hist[0].rd != 0)) return 1'b0;
    return (id_uses_rs1 && hist[0].rd == int'(id_rs1)) ||
           (id_uses_rs2 && hist[0].rd == int'(id_rs2));
  endfunction

  function automatic void m_step();
    bit [1:0] na, nb;
    if (!rst_n) begin
      m_clear();
      return;
    end
    if (hold) return;
    if (flush || m_stall()) begin
      hist[2] = hist[1]; hist[1] = hist[0];
      hist[0] = '{rd: 0, wr: 1'b0, ld: 1'b0};
      m_a = 2'b00; m_b = 2'b00;
    end else begin
      na = m_sel(int'(id_rs1), id_uses_rs1);
      nb = m_sel(int'(id_rs2), id_uses_rs2);
      hist[2] = hist[1]; hist[1] = hist[0];
      hist[0] = '{rd: int'(id_rd), wr: id_regwrite && id_valid, ld: id_memread && id_valid};
      m_a = na; m_b = nb;
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    m_step();
    #1;
  endtask

  task automatic drive(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                       input int rd, input bit rw, input bit mr);
    id_valid = v; id_rs1 = 5'(rs1); id_uses_rs1 = u1; id_rs2 = 5'(rs2); id_uses_rs2 = u2;
    id_rd = 5'(rd); id_regwrite = rw; id_memread = mr;
  endtask

  task automatic nop();
    drive(1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic drain();
    nop(); flush = 0; hold = 0;
    repeat (3) tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; flush = 0; hold = 0; nop();
    m_clear();
    for (int i = 0; i < 4; i++) begin
      drive($urandom_range(0, 1), $urandom_range(0, 31), $urandom_range(0, 1),
            $urandom_range(0, 31), $urandom_range(0, 1), $urandom_range(0, 31),
            $urandom_range(0, 1), $urandom_range(0, 1));
      flush = 1'($urandom_range(0, 1)); hold = 1'($urandom_range(0, 1));
      tick();
      total++;
      if ({fwd_a_sel1, fwd_a_sel0, fwd_b_sel1, fwd_b_sel0, stall_load_use} !== 5'b0) begin
        bad++;
        $display("FAIL reset_outputs got=%b%b%b%b stall=%b required=0000 stall=0",
                 fwd_a_sel1, fwd_a_sel0, fwd_b_sel1, fwd_b_sel0, stall_load_use);
      end
    end
    @(negedge clk);
    rst_n = 1'b1; flush = 0; hold = 0;
    drive(1, 2, 1, 3, 1, 1, 1, 0);   // add x1, x2, x3
    #1;
    tick();
    total++;
    if ({fwd_a_sel1, fwd_a_sel0, fwd_b_sel1, fwd_b_sel0} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_first_instr got=%b%b/%b%b required=00/00",
               fwd_a_sel1, fwd_a_sel0, fwd_b_sel1, fwd_b_sel0);
    end
  endtask

  task automatic test_exmem_forward();
    drain();
    drive(1, 1, 1, 2, 1, 5, 1, 0); tick();   // add x5
    drive(1, 5, 1, 6, 1, 7, 1, 0); #1;       // sub x7, x5, x6
    total++;
    if (stall_load_use !== 1'b0) begin
      bad++; $display("FAIL exmem_no_stall got=%b required=0", stall_load_use);
    end
    tick();
    total++;
    if ({fwd_a_sel1, fwd_a_sel0, fwd_b_sel1, fwd_b_sel0} !== 4'b1000) begin
      bad++; $display("FAIL exmem_a10 got=%b%b/%b%b required=10/00",
                      fwd_a_sel1, fwd_a_sel0, fwd_b_sel1, fwd_b_sel0);
    end
    drain();
    drive(1, 1, 1, 2, 1, 0, 1, 0); tick();   // add x0
    drive(1, 0, 1, 6, 1, 7, 1, 0); tick();   // sub x7, x0, x6
    total++;
    if ({fwd_a_sel1, fwd_a_sel0} !== 2'b00) begin
      bad++; $display("FAIL exmem_rd0 got=%b%b required=00", fwd_a_sel1, fwd_a_sel0);
    end
    drain();
    drive(1, 1, 1, 2, 1, 5, 1, 0); tick();   // add x5
    drive(1, 5, 1, 5, 1, 8, 1, 0); tick();   // add x8, x5, x5
    total++;
    if ({fwd_a_sel1, fwd_a_sel0, fwd_b_sel1, fwd_b_sel0} !== 4'b1010) begin
      bad++; $display("FAIL same_rs_both got=%b%b/%b%b required=10/10",
                      fwd_a_sel1, fwd_a_sel0, fwd_b_sel1, fwd_b_sel0);
    end
  endtask

  task automatic test_load_use();
    drain();
    drive(1, 1, 1, 0, 0, 7, 1, 1); tick();   // lw x7, 0(x1)
    drive(1, 2, 1, 7, 1, 8, 1, 0); #1;       // add x8, x2, x7
    total++;
    if (stall_load_use !== 1'b1) begin
      bad++; $display("FAIL load_use_stall got=%b required=1", stall_load_use);
    end
    tick();
    total++;
    if ({fwd_a_sel1, fwd_a_sel0, fwd_b_sel1, fwd_b_sel0} !== 4'b0000) begin
      bad++; $display("FAIL load_use_bubble got=%b%b/%b%b required=00/00",
                      fwd_a_sel1, fwd_a_sel0, fwd_b_sel1, fwd_b_sel0);
    end
    total++;
    if (stall_load_use !== 1'b0) begin
      bad++; $display("FAIL load_use_one_cycle got=%b required=0", stall_load_use);
    end
    tick();                                  // retried add
    total++;
    if ({fwd_a_sel1, fwd_a_sel0, fwd_b_sel1, fwd_b_sel0} !== 4'b0001) begin
      bad++; $display("FAIL load_use_retry got=%b%b/%b%b required=00/01",
                      fwd_a_sel1, fwd_a_sel0, fwd_b_sel1, fwd_b_sel0);
    end
  endtask

  task automatic test_priority();
    drain();
    drive(1, 1, 1, 2, 1, 3, 1, 0); tick();   // add x3
    drive(1, 4, 1, 5, 1, 3, 1, 0); tick();   // add x3
    drive(1, 3, 1, 0, 0, 9, 1, 0); tick();   // or x9, x3
    total++;
    if ({fwd_a_sel1, fwd_a_sel0} !== 2'b10) begin
      bad++; $display("FAIL prio_ex_wins got=%b%b required=10", fwd_a_sel1, fwd_a_sel0);
    end
    drain();
    drive(1, 1, 1, 2, 1, 3, 1, 0); tick();   // add x3
    nop(); tick();
    drive(1, 3, 1, 0, 0, 9, 1, 0); tick();   // or x9, x3
    total++;
    if ({fwd_a_sel1, fwd_a_sel0} !== 2'b01) begin
      bad++; $display("FAIL prio_mem got=%b%b required=01", fwd_a_sel1, fwd_a_sel0);
    end
  endtask

  task automatic test_hold_flush();
    drain();
    drive(1, 1, 1, 0, 0, 4, 1, 0); tick();   // add x4
    drive(1, 4, 1, 0, 0, 7, 1, 1); tick();   // lw x7, 0(x4) -> a=10
    drive(1, 2, 1, 7, 1, 8, 1, 0);           // dependent add
    hold = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (stall_load_use !== 1'b0) begin
        bad++; $display("FAIL hold_no_stall cyc=%0d got=%b required=0", i, stall_load_use);
      end
      tick();
      total++;
      if ({fwd_a_sel1, fwd_a_sel0, fwd_b_sel1, fwd_b_sel0} !== 4'b1000) begin
        bad++; $display("FAIL hold_frozen cyc=%0d got=%b%b/%b%b required=10/00", i,
                        fwd_a_sel1, fwd_a_sel0, fwd_b_sel1, fwd_b_sel0);
      end
    end
    hold = 0; #1;
    total++;
    if (stall_load_use !== 1'b1) begin
      bad++; $display("FAIL hold_release_stall got=%b required=1", stall_load_use);
    end
    tick(); tick();
    total++;
    if ({fwd_b_sel1, fwd_b_sel0} !== 2'b01) begin
      bad++; $display("FAIL hold_retry got=%b%b required=01", fwd_b_sel1, fwd_b_sel0);
    end
    drain();
    drive(1, 1, 1, 0, 0, 7, 1, 1); tick();   // lw x7
    drive(1, 2, 1, 7, 1, 8, 1, 0); flush = 1; #1;
    total++;
    if (stall_load_use !== 1'b0) begin
      bad++; $display("FAIL flush_no_stall got=%b required=0", stall_load_use);
    end
    tick();
    total++;
    if ({fwd_a_sel1, fwd_a_sel0, fwd_b_sel1, fwd_b_sel0} !== 4'b0000) begin
      bad++; $display("FAIL flush_selects got=%b%b/%b%b required=00/00",
                      fwd_a_sel1, fwd_a_sel0, fwd_b_sel1, fwd_b_sel0);
    end
    flush = 0;
    drive(1, 7, 1, 0, 0, 9, 1, 0); tick();   // lw now in MEM -> a=01
    total++;
    if ({fwd_a_sel1, fwd_a_sel0} !== 2'b01) begin
      bad++; $display("FAIL flush_then_mem got=%b%b required=01", fwd_a_sel1, fwd_a_sel0);
    end
  endtask

  task automatic test_wb_hold();
    bit [1:0] exp_a;
    exp_a = WB_EN ? 2'b11 : 2'b00;
    drain();
    drive(1, 1, 1, 2, 1, 9, 1, 0); tick();   // add x9
    nop(); tick(); tick();
    drive(1, 9, 1, 0, 0, 10, 1, 0); tick();  // and x10, x9
    total++;
    if ({fwd_a_sel1, fwd_a_sel0} !== exp_a) begin
      bad++; $display("FAIL wb_hold got=%b%b required=%b", fwd_a_sel1, fwd_a_sel0, exp_a);
    end
  endtask

  task automatic test_async_reset();
    drain();
    drive(1, 1, 1, 0, 0, 7, 1, 1); tick();   // lw x7
    drive(1, 7, 1, 0, 0, 8, 1, 0); #1;
    total++;
    if (stall_load_use !== 1'b1) begin
      bad++; $display("FAIL async_pre_stall got=%b required=1", stall_load_use);
    end
    #1 rst_n = 1'b0;
    #1;
    total++;
    if ({stall_load_use, fwd_a_sel1, fwd_a_sel0, fwd_b_sel1, fwd_b_sel0} !== 5'b0) begin
      bad++; $display("FAIL async_reset got=stall %b sel %b%b/%b%b required=0 00/00",
                      stall_load_use, fwd_a_sel1, fwd_a_sel0, fwd_b_sel1, fwd_b_sel0);
    end
    m_clear();
    @(negedge clk);
    rst_n = 1'b1;
    nop();
    #1;
  endtask

  task automatic test_random();
    bit [1:0] ea, eb;
    bit       es;
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 7) != 0, $urandom_range(0, 3), $urandom_range(0, 1),
            $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3),
            $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
      flush = ($urandom_range(0, 9) == 0);
      hold  = ($urandom_range(0, 9) == 0);
      #1;
      es = m_stall();
      total++;
      if (stall_load_use !== es) begin
        bad++; $display("FAIL rand_stall cyc=%0d got=%b required=%b", i, stall_load_use, es);
      end
      tick();
      ea = m_a; eb = m_b;
      total++;
      if ({fwd_a_sel1, fwd_a_sel0, fwd_b_sel1, fwd_b_sel0} !== {ea, eb}) begin
        bad++; $display("FAIL rand_sel cyc=%0d got=%b%b/%b%b required=%b/%b", i,
                        fwd_a_sel1, fwd_a_sel0, fwd_b_sel1, fwd_b_sel0, ea, eb);
      end
    end
    flush = 0; hold = 0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_exmem_forward();
    test_load_use();
    test_priority();
    test_hold_flush();
    test_wb_hold();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
